// File: rtl/asrv32_sim_console.sv
// Simulation console: memory-mapped TX FIFO drained onto an 8N1 line,
// plus a sticky tohost exit-word capture for ending SoC runs.
module asrv32_sim_console #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_in,
    input  logic [3:0]  i_wr_mask,
    output logic [31:0] o_data_out,
    output logic        o_ack,
    output logic        o_stall,
    output logic        o_uart_tx,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_byte,
    output logic        o_halt,
    output logic [30:0] o_exit_code
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   tick_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            tx_valid_q;
    logic [7:0]      tx_byte_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    logic            ack_q;
    logic [31:0]     rdata_q;
    logic [31:0]     rdata_d;
    logic            halt_q;
    logic [30:0]     exit_q;

    logic            hit;
    logic [1:0]      offset;
    logic            empty;
    logic            full;
    logic            busy;
    logic            stall;
    logic            accept;
    logic            push;
    logic            pop;
    logic            tohost;
    logic [31:0]     status;

    always_comb begin
        hit    = (i_data_addr[31:4] == BASE_ADDR[31:4]);
        offset = i_data_addr[3:2];
        empty  = (count_q == '0);
        full   = (count_q == CNT_FULL);
        busy   = (state_q != IDLE);
        // Only a TXDATA write can be refused; everything else completes.
        stall  = hit & i_wr_en & (offset == 2'd0) & full;
        accept = hit & (i_rd_en | i_wr_en) & ~stall;
        push   = accept & i_wr_en & (offset == 2'd0) & i_wr_mask[0];
        pop    = (state_q == IDLE) & ~empty;
        tohost = accept & i_wr_en & (offset == 2'd2)
               & (i_wr_mask == 4'hf) & i_data_in[0];

        status          = '0;
        status[AW:0]    = count_q;
        status[8]       = empty;
        status[9]       = full;
        status[10]      = busy;
        status[16]      = halt_q;

        rdata_d = '0;
        if (accept & i_rd_en & (offset == 2'd1)) begin
            rdata_d = status;
        end

        count_d = count_q;
        if (push & ~pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop & ~push) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data_in[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            halt_q   <= 1'b0;
            exit_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ack_q   <= accept;
            rdata_q <= rdata_d;
            if (tohost & ~halt_q) begin
                halt_q <= 1'b1;
                exit_q <= i_data_in[31:1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            tx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q    <= mem_q[rd_ptr_q];
                        tx_byte_q  <= mem_q[rd_ptr_q];
                        tx_valid_q <= 1'b1;
                        tx_q       <= 1'b0;
                        tick_q     <= '0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (tick_q == BIT_LAST) begin
                        tick_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == BIT_LAST) begin
                        tick_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == BIT_LAST) begin
                        tick_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_stall     = stall;
    assign o_ack       = ack_q;
    assign o_data_out  = rdata_q;
    assign o_uart_tx   = tx_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_tx_byte   = tx_byte_q;
    assign o_halt      = halt_q;
    assign o_exit_code = exit_q;

endmodule

// File: tb/tb_asrv32_sim_console.sv
// Bench for asrv32_sim_console: frame-timing model compared every cycle,
// plus directed bus transactions with literal expectations.
module tb_asrv32_sim_console;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;
    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rd_en = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [31:0] i_data_addr = '0;
    logic [31:0] i_data_in = '0;
    logic [3:0]  i_wr_mask = '0;
    logic [31:0] o_data_out;
    logic        o_ack;
    logic        o_stall;
    logic        o_uart_tx;
    logic        o_tx_valid;
    logic [7:0]  o_tx_byte;
    logic        o_halt;
    logic [30:0] o_exit_code;

    asrv32_sim_console #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rd_en     (i_rd_en),
        .i_wr_en     (i_wr_en),
        .i_data_addr (i_data_addr),
        .i_data_in   (i_data_in),
        .i_wr_mask   (i_wr_mask),
        .o_data_out  (o_data_out),
        .o_ack       (o_ack),
        .o_stall     (o_stall),
        .o_uart_tx   (o_uart_tx),
        .o_tx_valid  (o_tx_valid),
        .o_tx_byte   (o_tx_byte),
        .o_halt      (o_halt),
        .o_exit_code (o_exit_code)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stall_cnt = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO contents as a queue, frame position as edges since pop.
    int          cyc = 0;
    int          pop_cyc = -1000;
    logic [7:0]  mq[$];
    logic [7:0]  cur_byte = '0;
    logic [7:0]  exp_byte = '0;
    logic        exp_valid = 0;
    logic        exp_ack = 0;
    logic [31:0] exp_data = '0;
    logic        exp_halt = 0;
    logic [30:0] exp_exit = '0;
    logic [7:0]  popped[$];

    function automatic logic m_line();
        int t;
        int k;
        t = cyc - pop_cyc;
        if (t >= FRAME) return 1'b1;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return cur_byte[k-1];
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size());
        s[8]  = (mq.size() == 0);
        s[9]  = (mq.size() == DEPTH);
        s[10] = ((cyc - pop_cyc) < FRAME);
        s[16] = exp_halt;
        return s;
    endfunction

    function automatic logic m_stall();
        return (i_data_addr[31:4] == BASE[31:4]) && i_wr_en
            && (i_data_addr[3:2] == 2'd0) && (mq.size() == DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            pop_cyc   = cyc - 1000;
            cur_byte  = '0;
            exp_valid = 0;
            exp_ack   = 0;
            exp_data  = '0;
            exp_halt  = 0;
            exp_exit  = '0;
        end else begin
            logic hit;
            logic acc;
            logic [1:0] off;
            hit = (i_data_addr[31:4] == BASE[31:4]);
            off = i_data_addr[3:2];
            acc = hit && (i_rd_en || i_wr_en) && !m_stall();
            exp_ack  = acc;
            exp_data = (acc && i_rd_en && off == 2'd1) ? m_status() : 32'h0;
            exp_valid = 0;
            if ((cyc - pop_cyc) >= FRAME && mq.size() > 0) begin
                cur_byte  = mq.pop_front();
                exp_byte  = cur_byte;
                exp_valid = 1;
                pop_cyc   = cyc + 1;
            end
            if (acc && i_wr_en && off == 2'd0 && i_wr_mask[0])
                mq.push_back(i_data_in[7:0]);
            if (acc && i_wr_en && off == 2'd2 && i_wr_mask == 4'hf
                && i_data_in[0] && !exp_halt) begin
                exp_halt = 1;
                exp_exit = i_data_in[31:1];
            end
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack", 32'(o_ack), 32'(exp_ack));
            chk("data_out", o_data_out, exp_data);
            chk("tx_valid", 32'(o_tx_valid), 32'(exp_valid));
            if (exp_valid) chk("tx_byte", 32'(o_tx_byte), 32'(exp_byte));
            chk("uart_tx", 32'(o_uart_tx), 32'(m_line()));
            chk("halt", 32'(o_halt), 32'(exp_halt));
            chk("exit_code", 32'(o_exit_code), 32'(exp_exit));
            chk("stall", 32'(o_stall), 32'(m_stall()));
        end
        if (o_tx_valid === 1'b1) popped.push_back(o_tx_byte);
    end

    logic        b_ack;
    logic [31:0] b_dat;

    // Present one access, hold it through any stall, return the ack cycle.
    task automatic bus(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       output logic ack, output logic [31:0] rdat);
        int guard;
        logic st;
        i_rd_en = rd;
        i_wr_en = wr;
        i_data_addr = a;
        i_data_in = d;
        i_wr_mask = m;
        guard = 0;
        do begin
            #1;
            st = o_stall;
            if (st) stall_cnt++;
            @(posedge clk);
            #1;
            guard++;
        end while (st && guard < 2000);
        if (st) begin
            tests++;
            fails++;
            $display("FAIL bus_timeout: stall still %b after %0d cycles", st, guard);
        end
        ack  = o_ack;
        rdat = o_data_out;
        i_rd_en = 0;
        i_wr_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
    endtask

    int pat[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;

        chk("reset_line", 32'(o_uart_tx), 32'h1);
        bus(1, 0, BASE + 4, 0, 0, b_ack, b_dat);
        chk("reset_status_ack", 32'(b_ack), 32'h1);
        chk("reset_status", b_dat, 32'h0000_0100);

        bus(0, 1, 32'h9000_0004, 0, 4'hf, b_ack, b_dat);
        chk("miss_ack", 32'(b_ack), 32'h0);
        bus(1, 0, BASE + 12, 0, 0, b_ack, b_dat);
        chk("off3_ack", 32'(b_ack), 32'h1);
        chk("off3_data", b_dat, 32'h0);

        // Single byte: pop one cycle after the push, then the 8N1 frame.
        bus(0, 1, BASE, 32'h41, 4'b0001, b_ack, b_dat);
        chk("txdata_ack", 32'(b_ack), 32'h1);
        chk("pre_pop_valid", 32'(o_tx_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("pop_valid", 32'(o_tx_valid), 32'h1);
        chk("pop_byte", 32'(o_tx_byte), 32'h41);
        for (int j = 0; j < FRAME; j++) begin
            if (j % CPB == 1) chk("frame_bit", 32'(o_uart_tx), 32'(pat[j / CPB]));
            if (j == 10) begin
                i_rd_en = 1;
                i_data_addr = BASE + 4;
            end
            if (j == 11) begin
                i_rd_en = 0;
                chk("busy_status", o_data_out, 32'h0000_0500);
            end
            @(posedge clk);
            #1;
        end
        chk("frame_end_line", 32'(o_uart_tx), 32'h1);
        bus(1, 0, BASE + 4, 0, 0, b_ack, b_dat);
        chk("idle_status", b_dat, 32'h0000_0100);

        // Overfill: the 18th write stalls until the second pop frees a slot.
        popped.delete();
        stall_cnt = 0;
        for (int i = 0; i < 18; i++)
            bus(0, 1, BASE, 32'h100 | (32'h10 + i), 4'b0001, b_ack, b_dat);
        chk("stall_cycles", 32'(stall_cnt), 32'd26);
        idle(18 * (FRAME + 1) + 20);
        chk("drain_count", 32'(popped.size()), 32'd18);
        for (int i = 0; i < 18; i++)
            if (i < popped.size())
                chk("drain_order", 32'(popped[i]), 32'h10 + i);

        bus(0, 1, BASE + 8, 32'h7, 4'b0001, b_ack, b_dat);
        chk("tohost_partial_ack", 32'(b_ack), 32'h1);
        chk("tohost_partial_halt", 32'(o_halt), 32'h0);
        bus(0, 1, BASE + 8, 32'h7, 4'b1111, b_ack, b_dat);
        chk("tohost_halt", 32'(o_halt), 32'h1);
        chk("tohost_exit3", 32'(o_exit_code), 32'd3);
        bus(0, 1, BASE + 8, 32'h1, 4'b1111, b_ack, b_dat);
        chk("tohost_sticky", 32'(o_exit_code), 32'd3);
        bus(1, 0, BASE + 4, 0, 0, b_ack, b_dat);
        chk("halt_status", b_dat, 32'h0001_0100);

        pulse_reset();
        chk("reset_halt", 32'(o_halt), 32'h0);
        bus(0, 1, BASE + 8, 32'h1, 4'b1111, b_ack, b_dat);
        chk("exit0_halt", 32'(o_halt), 32'h1);
        chk("exit0_code", 32'(o_exit_code), 32'd0);
        bus(1, 0, BASE + 4, 0, 0, b_ack, b_dat);
        chk("exit0_status", b_dat, 32'h0001_0100);
        bus(0, 1, BASE + 8, 32'h7, 4'b1111, b_ack, b_dat);
        chk("exit0_sticky", 32'(o_exit_code), 32'd0);

        // Reset in the middle of DATA with three bytes still queued.
        for (int i = 0; i < 4; i++)
            bus(0, 1, BASE, 32'hA0 + i, 4'b0001, b_ack, b_dat);
        idle(10);
        #2 rst = 1;
        #1;
        chk("midrst_line", 32'(o_uart_tx), 32'h1);
        chk("midrst_valid", 32'(o_tx_valid), 32'h0);
        chk("midrst_halt", 32'(o_halt), 32'h0);
        @(posedge clk);
        #1 rst = 0;
        popped.delete();
        bus(1, 0, BASE + 4, 0, 0, b_ack, b_dat);
        chk("midrst_status", b_dat, 32'h0000_0100);
        idle(100);
        chk("midrst_no_tx", 32'(popped.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
